// File: rtl/burst_mode_ctrl.sv
// burst_mode_ctrl
//   Sequencing controller for a burst-mode CellularRAM datapath.
//   After reset it waits INIT_CYCLES, then writes the burst configuration
//   register through MemCre.  After that it serves single-requester burst
//   reads and writes of BURST_LEN 16-bit words.
//
//   Optional feature macro: BURST_WAIT_TIMEOUT_EN
//     defined   - a MemWait stall counter aborts a burst after TIMEOUT
//                 stalled cycles and sets the sticky Error flag.
//     undefined - WAIT states hold indefinitely and Error is tied low.
//
// Ports
//   Clk, Reset          clock, asynchronous active-high reset
//   ReqRead, ReqWrite   host requests, sampled in IDLE (read wins)
//   ReqAddr             burst start word address
//   WrData / WrReady    host write word / pulse when it is consumed
//   RdData              word sampled from the datapath bus
//   RdOut / RdValid     registered read word / pulse when RdOut is new
//   MemWait             memory WAIT, high = data not ready
//   Mode                datapath mode: 00 Idle, 01 Read, 10 Con, 11 Write
//   MemAddr             latched burst address
//   MemAdv_n, MemCe_n, MemOe_n, MemWe_n   active-low memory strobes
//   MemCre, MemClkEn    control-register enable, memory clock enable
//   Busy, CfgDone, Error  status flags
module burst_mode_ctrl #(
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned INIT_CYCLES = 150,
   parameter int unsigned CFG_CYCLES  = 4,
   parameter int unsigned TIMEOUT     = 32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ReqRead,
   input  logic        ReqWrite,
   input  logic [19:0] ReqAddr,
   input  logic [15:0] WrData,
   output logic        WrReady,
   input  logic [15:0] RdData,
   output logic [15:0] RdOut,
   output logic        RdValid,
   input  logic        MemWait,
   output logic [1:0]  Mode,
   output logic [19:0] MemAddr,
   output logic        MemAdv_n,
   output logic        MemCe_n,
   output logic        MemOe_n,
   output logic        MemWe_n,
   output logic        MemCre,
   output logic        MemClkEn,
   output logic        Busy,
   output logic        CfgDone,
   output logic        Error
);

   localparam int unsigned CNT_W = $clog2(INIT_CYCLES + CFG_CYCLES + BURST_LEN + 1);

   typedef enum logic [3:0] {
      PWR_WAIT, CFG, CFG_END, IDLE,
      RD_ADDR, RD_WAIT, RD_DATA,
      WR_ADDR, WR_WAIT, WR_DATA,
      BURST_END
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [19:0]      addr_nx;
   logic [15:0]      rd_out_nx;
   logic             rd_valid_nx;
   logic             cfg_done_nx;
   logic             timeout_hit;

   // Write data travels straight from host to datapath; the controller only
   // paces it with WrReady.
   logic unused_wr_data;
   assign unused_wr_data = ^WrData;

`ifdef BURST_WAIT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] tcnt, tcnt_nx;
   logic            error_q, error_nx;
   logic            stalled;

   assign stalled     = (state inside {RD_WAIT, WR_WAIT, RD_DATA, WR_DATA}) && MemWait;
   assign timeout_hit = stalled && (tcnt == TO_W'(TIMEOUT - 1));

   always_comb begin
      tcnt_nx  = stalled ? tcnt + TO_W'(1) : '0;
      error_nx = error_q | timeout_hit;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         tcnt    <= '0;
         error_q <= 1'b0;
      end else begin
         tcnt    <= tcnt_nx;
         error_q <= error_nx;
      end
   end

   assign Error = error_q;
`else
   assign timeout_hit = 1'b0;
   assign Error       = 1'b0;
`endif

   assign Busy = (state != IDLE);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state   <= PWR_WAIT;
         cnt     <= '0;
         MemAddr <= '0;
         RdOut   <= '0;
         RdValid <= 1'b0;
         CfgDone <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         MemAddr <= addr_nx;
         RdOut   <= rd_out_nx;
         RdValid <= rd_valid_nx;
         CfgDone <= cfg_done_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      addr_nx     = MemAddr;
      rd_out_nx   = RdOut;
      rd_valid_nx = 1'b0;
      cfg_done_nx = CfgDone;
      Mode        = 2'b00;
      MemAdv_n    = 1'b1;
      MemCe_n     = 1'b1;
      MemOe_n     = 1'b1;
      MemWe_n     = 1'b1;
      MemCre      = 1'b0;
      MemClkEn    = 1'b0;
      WrReady     = 1'b0;

      unique case (state)
         PWR_WAIT: begin
            if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
               cnt_nx   = '0;
               state_nx = CFG;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         CFG: begin
            Mode     = 2'b10;
            MemCre   = 1'b1;
            MemAdv_n = 1'b0;
            MemCe_n  = 1'b0;
            MemWe_n  = 1'b0;
            if (cnt == CNT_W'(CFG_CYCLES - 1)) begin
               cnt_nx   = '0;
               state_nx = CFG_END;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         CFG_END: begin
            cfg_done_nx = 1'b1;
            state_nx    = IDLE;
         end
         IDLE: begin
            cnt_nx = '0;
            if (ReqRead) begin
               addr_nx  = ReqAddr;
               state_nx = RD_ADDR;
            end else if (ReqWrite) begin
               addr_nx  = ReqAddr;
               state_nx = WR_ADDR;
            end
         end
         RD_ADDR, WR_ADDR: begin
            Mode     = (state == WR_ADDR) ? 2'b11 : 2'b01;
            MemClkEn = 1'b1;
            MemCe_n  = 1'b0;
            MemAdv_n = 1'b0;
            MemWe_n  = (state != WR_ADDR);
            state_nx = (state == WR_ADDR) ? WR_WAIT : RD_WAIT;
         end
         RD_WAIT, WR_WAIT: begin
            Mode     = (state == WR_WAIT) ? 2'b11 : 2'b01;
            MemClkEn = 1'b1;
            MemCe_n  = 1'b0;
            if (timeout_hit)
               state_nx = BURST_END;
            else if (!MemWait)
               state_nx = (state == WR_WAIT) ? WR_DATA : RD_DATA;
         end
         RD_DATA, WR_DATA: begin
            Mode     = (state == WR_DATA) ? 2'b11 : 2'b01;
            MemClkEn = 1'b1;
            MemCe_n  = 1'b0;
            MemOe_n  = (state != RD_DATA);
            if (timeout_hit) begin
               state_nx = BURST_END;
            end else if (!MemWait) begin
               // One word moves on every non-stalled data cycle.
               if (state == RD_DATA) begin
                  rd_out_nx   = RdData;
                  rd_valid_nx = 1'b1;
               end else begin
                  WrReady = 1'b1;
               end
               if (cnt == CNT_W'(BURST_LEN - 1)) begin
                  cnt_nx   = '0;
                  state_nx = BURST_END;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         BURST_END: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            cnt_nx   = '0;
            state_nx = PWR_WAIT;
         end
      endcase
   end

endmodule

// File: doc/burst_mode_ctrl.md
Name: burst_mode_ctrl

Overview:
Sequencing controller for the burst-mode CellularRAM datapath.
- After reset, drives the datapath into configuration mode and writes the burst configuration register through the control-register-enable path.
- Then serves single-requester burst read and burst write transactions of BURST_LEN 16-bit words.
- Generates the memory strobes and the 2-bit datapath Mode, and gives the host a word-level valid/ready interface.

Parameters:
BURST_LEN, 4, words per burst (legal values 4, 8, 16)
INIT_CYCLES, 150, power-up wait cycles before configuration
CFG_CYCLES, 4, cycles WE_n/CE_n are held low during the configuration write
TIMEOUT, 32, maximum cycles in a WAIT state (used only with the optional feature)

Ports:
Clk  in  1  system clock; memory clock runs in phase when MemClkEn=1
Reset  in  1  asynchronous, active-high reset
ReqRead  in  1  host read request, sampled in IDLE
ReqWrite  in  1  host write request, sampled in IDLE
ReqAddr  in  20  burst start word address
WrData  in  16  write word from host
WrReady  out  1  pulse: WrData consumed this cycle
RdData  in  16  word sampled from the datapath bus
RdOut  out  16  registered read word to host
RdValid  out  1  pulse: RdOut valid
MemWait  in  1  memory WAIT, active-high = data not ready
Mode  out  2  datapath mode: 00 Idle, 01 Read, 10 Con, 11 Write
MemAddr  out  20  address to memory (latched ReqAddr)
MemAdv_n, MemCe_n, MemOe_n, MemWe_n  out  1 each  memory strobes, active-low
MemCre  out  1  control-register enable
MemClkEn  out  1  enable for the memory clock
Busy  out  1  high in every state except IDLE
CfgDone  out  1  set once configuration completes, cleared only by Reset
Error  out  1  sticky timeout flag (optional feature; tied 0 without it)

Behaviour:
- Reset values: all strobes 1; MemCre 0; MemClkEn 0; Mode 00; MemAddr 0; RdOut 0; RdValid, WrReady, CfgDone, Error 0; Busy 1; state PWR_WAIT; counters 0.
- PWR_WAIT: count INIT_CYCLES, then go to CFG.
- CFG: Mode=10, MemCre=1, MemAdv_n=0, MemCe_n=0, MemWe_n=0 for CFG_CYCLES cycles. Then CFG_END: one cycle with all strobes high and MemCre=0. Then set CfgDone and go to IDLE.
- IDLE: Mode=00, strobes high, MemClkEn=0.
  - If ReqRead is high, latch ReqAddr and go to RD_ADDR.
  - Else if ReqWrite is high, go to WR_ADDR (read has priority when both are high).
  - Requests made before CfgDone are ignored.
- RD_ADDR / WR_ADDR: one cycle. MemClkEn=1, MemCe_n=0, MemAdv_n=0; WR_ADDR also drives MemWe_n=0. Mode=01 (read) or 11 (write).
- RD_WAIT / WR_WAIT: MemAdv_n=1, MemCe_n=0. Remain while MemWait=1; exit the first cycle MemWait=0.
- RD_DATA: MemOe_n=0. Each cycle with MemWait=0: register RdData into RdOut, pulse RdValid (visible the following cycle), increment the word counter. MemWait=1 mid-burst stalls the counter with no RdValid.
- WR_DATA: WrReady pulses each cycle with MemWait=0; the datapath drives WrData; the counter increments. The host must present the next word the cycle after WrReady.
- When the counter reaches BURST_LEN-1 with MemWait=0, go to END. END: one cycle, all strobes high, MemClkEn=0, Mode=00, counter cleared. Then go to IDLE.
- Exactly BURST_LEN RdValid or WrReady pulses per burst; the address never wraps inside the controller, and the memory's burst wrap setting applies.
- Minimum read latency (request to first RdValid) is 4 cycles: ADDR, WAIT, DATA, register.
- Reset mid-burst: immediate return to reset values. Configuration is re-run (CfgDone=0).
- Mode is never 11 unless the state is WR_*, so the datapath bus is tri-stated otherwise.

Optional Feature:
BURST_WAIT_TIMEOUT_EN
- Defined: a counter runs in RD_WAIT/WR_WAIT and on mid-burst stalls. It clears on any MemWait=0 cycle. When it reaches TIMEOUT, set Error (sticky until Reset) and go to END, aborting the burst with no further RdValid/WrReady.
- Undefined: no counter; WAIT states hold indefinitely; Error is tied 0.

Test Plan:
- Reset released, no requests -> Busy=1; MemCre=1 and Mode=10 for exactly 4 cycles starting at cycle 151; CfgDone=1 at cycle 156; Busy=0.
- ReqRead with ReqAddr=20'h00100, MemWait=0, RdData counting 1..4 -> four consecutive RdValid pulses with RdOut=1,2,3,4; MemAddr=20'h00100; first RdValid 4 cycles after the request.
- ReqWrite with WrData=16'hA5A5, MemWait high for 3 cycles then low -> Mode=11 throughout; 4 WrReady pulses starting after WAIT; MemWe_n=0 only in the WR_ADDR cycle.
- ReqRead and ReqWrite asserted together -> read burst executes first; write accepted after END if ReqWrite is still high.
- MemWait raised for 2 cycles after word 2 of a read -> RdValid gap of 2 cycles; still exactly 4 pulses total.
- Reset asserted mid write burst -> all strobes 1 immediately, CfgDone=0, configuration sequence repeats. With BURST_WAIT_TIMEOUT_EN defined and MemWait held high: Error=1 after 32 WAIT cycles, then return to IDLE.
